core_ctrl: RTL and testbench
============================

// Module: core_ctrl
// PURPOSE
//  Sequencer for one core pass: fetches weights from the 32b x 2048 activation/weight SRAM into
//  the corelet L0, loads them into the 8x8 array, streams n_len activation vectors, drains the
//  OFIFO and writes the psums to the psum SRAM. Sits beside corelet/SRAM inside core.
//  Data buses stay in core; this block drives control and address only.
// PARAMETERS
//  row      8   array rows = number of weight words fetched per kernel
//  col      8   array columns; sets load propagation time
//  sram_aw  11  SRAM address width (2048 words)
//  len_w    11  width of n_len / vector counters
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        async, active-high
//  start       in   1        pass request; sampled only when busy=0
//  w_base      in   sram_aw  first weight word address
//  x_base      in   sram_aw  first activation word address
//  psum_base   in   sram_aw  first psum write address
//  n_len       in   len_w    activation vectors this pass (0 allowed)
//  busy        out  1        high from accepted start until done cycle inclusive
//  done        out  1        1-cycle pulse at end of pass
//  sram_cen    out  1        act/weight SRAM chip enable, active-low
//  sram_wen    out  1        act/weight SRAM write enable, active-low; tied 1 (read-only here)
//  sram_a      out  sram_aw  act/weight SRAM address
//  l0_wr       out  1        push SRAM Q into L0
//  l0_rd       out  1        pop L0 into array west edge
//  load        out  1        array weight-load mode
//  execute     out  1        array execute mode
//  ofifo_valid in   1        OFIFO holds a complete psum vector
//  ofifo_rd    out  1        pop one OFIFO vector
//  psum_cen    out  1        psum SRAM enable, active-low
//  psum_wen    out  1        psum SRAM write enable, active-low
//  psum_a      out  sram_aw  psum SRAM address
// BEHAVIOUR
//  Reset (async, any state): IDLE; busy=done=l0_wr=l0_rd=load=execute=ofifo_rd=0;
//   sram_cen=sram_wen=psum_cen=psum_wen=1; addresses and counters 0. Abandoned pass is not resumed.
//  IDLE: start&!busy -> latch all cfg inputs, go W_FETCH. Cfg changes after accept are ignored.
//  W_FETCH (row cycles): sram_cen=0, sram_a=w_base+i; l0_wr=1 one cycle later (1-cycle SRAM read).
//  W_LOAD (row+col cycles, starts after last l0_wr): l0_rd=1 for first row cycles; load=1 all cycles.
//   Exit: n_len==0 -> DONE, else X_STREAM.
//  X_STREAM (n_len cycles): sram_a=x_base+j, cen=0; l0_wr at j+1, l0_rd&execute at j+2. -> DRAIN.
//  DRAIN: wait until written==n_len, then DONE. Pipeline tails of l0_wr/l0_rd/execute complete here.
//  Readout (X_STREAM/DRAIN only): ofifo_valid -> ofifo_rd=1 that cycle; next cycle psum_cen=0,
//   psum_wen=0, psum_a=psum_base+k, k++. ofifo_valid outside these states is ignored.
//  DONE: done=1, busy=1 for one cycle -> IDLE; start in this cycle ignored.
//  Address arithmetic modulo 2^sram_aw (wraps 2047->0); no overflow flag.
//  Simultaneous SRAM read and psum write are legal (separate macros).
//  execute and load never high in the same cycle; ofifo_rd never exceeds n_len pops per pass.
// STRUCTURE
//  core_pkg.vh: state encodings (IDLE,W_FETCH,W_LOAD,X_STREAM,DRAIN,DONE), SRAM_AW, read latency 1.
//  Sub-module ctrl_addr_cnt (base + count, load/inc/clear, wrap) instanced 3x: weight/act/psum.
//  Delay of l0_wr/l0_rd/execute: shift registers in core_ctrl; one-hot or binary state, registered outputs.
// TESTING
//  1 reset mid-X_STREAM (n_len=16, cycle 5) -> all outputs at reset values same cycle; idle after release.
//  2 w_base=0x010,n_len=4,x_base=0x100,psum_base=0x200 -> sram_a 0x010..0x017 then 0x100..0x103;
//    l0_wr 12 cycles; load 16 cycles; 4 psum writes at 0x200..0x203; one done pulse.
//  3 n_len=0 -> W_FETCH/W_LOAD only; no execute, no ofifo_rd, no psum write; done after W_LOAD.
//  4 x_base=0x7FE,n_len=4 -> sram_a 0x7FE,0x7FF,0x000,0x001; psum_base=0x7FF wraps likewise.
//  5 ofifo_valid toggled 1-0-1 during DRAIN -> ofifo_rd only on valid cycles; done only after 4th write.
//  6 start held high through pass and in DONE -> exactly one pass; next pass only if start held in IDLE.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared sizes and sequencer state encoding for the core pass controller.
package core_ctrl_pkg;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int SRAM_AW = 11;
  localparam int LEN_W = 11;
  typedef enum logic [2:0] {S_IDLE, S_W_FETCH, S_W_LOAD, S_X_STREAM, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/core_ctrl_addr_cnt.sv
// core_ctrl_addr_cnt: base-plus-count address register with clear/load/increment, wrapping at 2^AW.
module core_ctrl_addr_cnt
  import core_ctrl_pkg::*;
#(
  parameter int AW = SRAM_AW
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic [AW-1:0] base_i,
  output logic [AW-1:0] addr_o
);
  logic [AW-1:0] addr_q, addr_d;
  always_comb addr_d = clear_i ? '0 : load_i ? base_i : inc_i ? addr_q + AW'(1) : addr_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) addr_q <= '0;
    else addr_q <= addr_d;
  assign addr_o = addr_q;
endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: sequences one core pass - weight fetch into L0, array weight load,
// activation streaming and OFIFO-to-psum-SRAM readout.
module core_ctrl
  import core_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [SRAM_AW-1:0] w_base_i,
  input  logic [SRAM_AW-1:0] x_base_i,
  input  logic [SRAM_AW-1:0] psum_base_i,
  input  logic [LEN_W-1:0]   n_len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               sram_cen_o,
  output logic               sram_wen_o,
  output logic [SRAM_AW-1:0] sram_a_o,
  output logic               l0_wr_o,
  output logic               l0_rd_o,
  output logic               load_o,
  output logic               execute_o,
  input  logic               ofifo_valid_i,
  output logic               ofifo_rd_o,
  output logic               psum_cen_o,
  output logic               psum_wen_o,
  output logic [SRAM_AW-1:0] psum_a_o
);
  localparam logic [LEN_W-1:0] ROW_L = LEN_W'(ROW);
  localparam logic [LEN_W-1:0] LOAD_LAST = LEN_W'(ROW + COL - 1);
  state_t state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, n_len_q, pops_q;
  logic [1:0] x_pipe_q;
  logic rd_q, psum_wr_q, accept, w_rd, x_rd, done_st;
  logic [SRAM_AW-1:0] w_a, x_a;
  assign accept = state_q == S_IDLE && start_i;
  assign w_rd = state_q == S_W_FETCH && cnt_q < ROW_L;
  assign x_rd = state_q == S_X_STREAM;
  assign done_st = state_q == S_DONE;
  // W_FETCH runs one extra cycle so the last SRAM word lands in L0 before loading starts;
  // DRAIN leaves only once every psum is popped and no execute is still in flight.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + LEN_W'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        state_d = start_i ? S_W_FETCH : S_IDLE;
      end
      S_W_FETCH: if (cnt_q == ROW_L) begin
        state_d = S_W_LOAD;
        cnt_d = '0;
      end
      S_W_LOAD: if (cnt_q == LOAD_LAST) begin
        state_d = n_len_q == '0 ? S_DONE : S_X_STREAM;
        cnt_d = '0;
      end
      S_X_STREAM: if (cnt_q == n_len_q - LEN_W'(1)) begin
        state_d = S_DRAIN;
        cnt_d = '0;
      end
      S_DRAIN: begin
        cnt_d = '0;
        state_d = pops_q == n_len_q && !x_pipe_q[0] ? S_DONE : S_DRAIN;
      end
      default: begin
        cnt_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      n_len_q <= '0;
      pops_q <= '0;
      rd_q <= 1'b0;
      x_pipe_q <= '0;
      psum_wr_q <= 1'b0;
    end else begin
      n_len_q <= accept ? n_len_i : n_len_q;
      pops_q <= accept ? '0 : ofifo_rd_o ? pops_q + LEN_W'(1) : pops_q;
      rd_q <= w_rd | x_rd;
      x_pipe_q <= {x_pipe_q[0], x_rd};
      psum_wr_q <= ofifo_rd_o;
    end
  core_ctrl_addr_cnt u_w_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(done_st), .load_i(accept),
    .inc_i(w_rd), .base_i(w_base_i), .addr_o(w_a)
  );
  core_ctrl_addr_cnt u_x_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(done_st), .load_i(accept),
    .inc_i(x_rd), .base_i(x_base_i), .addr_o(x_a)
  );
  core_ctrl_addr_cnt u_p_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(done_st), .load_i(accept),
    .inc_i(psum_wr_q), .base_i(psum_base_i), .addr_o(psum_a_o)
  );
  assign busy_o = state_q != S_IDLE;
  assign done_o = done_st;
  assign sram_cen_o = ~(w_rd | x_rd);
  assign sram_wen_o = 1'b1;
  assign sram_a_o = x_rd ? x_a : w_a;
  assign l0_wr_o = rd_q;
  assign l0_rd_o = (state_q == S_W_LOAD && cnt_q < ROW_L) | x_pipe_q[1];
  assign load_o = state_q == S_W_LOAD;
  assign execute_o = x_pipe_q[1];
  assign ofifo_rd_o = (state_q == S_X_STREAM || state_q == S_DRAIN) && ofifo_valid_i && pops_q != n_len_q;
  assign psum_cen_o = ~psum_wr_q;
  assign psum_wen_o = ~psum_wr_q;
endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: table, random and corner-case passes checked against an event-list model of a core pass.
module tb_core_ctrl;
  import core_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ofv = 1'b0;
  logic [10:0] w_base = '0, x_base = '0, psum_base = '0, n_len = '0;
  logic busy, done, sram_cen, sram_wen, l0_wr, l0_rd, load, execute, ofifo_rd, psum_cen, psum_wen;
  logic [10:0] sram_a, psum_a;
  core_ctrl dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .w_base_i(w_base), .x_base_i(x_base),
    .psum_base_i(psum_base), .n_len_i(n_len), .busy_o(busy), .done_o(done),
    .sram_cen_o(sram_cen), .sram_wen_o(sram_wen), .sram_a_o(sram_a), .l0_wr_o(l0_wr),
    .l0_rd_o(l0_rd), .load_o(load), .execute_o(execute), .ofifo_valid_i(ofv),
    .ofifo_rd_o(ofifo_rd), .psum_cen_o(psum_cen), .psum_wen_o(psum_wen), .psum_a_o(psum_a)
  );
  always #5 clk = ~clk;
  typedef struct {
    string name;
    int w, x, p, n, vmode, exp_reads, exp_writes, exp_last_rd, exp_last_psum;
  } vec_t;
  vec_t vecs[5];
  int n_checks = 0, n_fail = 0;
  int rd_a[$], rd_c[$], wr_c[$], l0rd_c[$], ld_c[$], ex_c[$], ps_a[$], ps_c[$], of_c[$], done_c[$];
  int busy_gap, viol, of_mis, exp_pop_last;
  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask
  function automatic logic [10:0] outs();
    return {busy, done, sram_cen, sram_wen, l0_wr, l0_rd, load, execute, ofifo_rd, psum_cen, psum_wen};
  endfunction
  // Expected behaviour: reads at cycles 1..8 (weights) and 26.. (activations) after accept,
  // l0_wr one cycle after each read, load on 10..25, execute two cycles after each activation read.
  task automatic run_pass(input string tag, input int w, input int x, input int p, input int n,
                          input int vmode, input bit hold);
    int cyc, pops, m, exp_done, ea, ec;
    bit e;
    rd_a.delete(); rd_c.delete(); wr_c.delete(); l0rd_c.delete(); ld_c.delete();
    ex_c.delete(); ps_a.delete(); ps_c.delete(); of_c.delete(); done_c.delete();
    busy_gap = 0; viol = 0; of_mis = 0; pops = 0; exp_pop_last = 0;
    @(posedge clk); #1;
    w_base = 11'(w); x_base = 11'(x); psum_base = 11'(p); n_len = 11'(n);
    start = 1'b1; ofv = 1'b0;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    w_base = 11'($urandom); x_base = 11'($urandom); psum_base = 11'($urandom); n_len = 11'($urandom);
    for (cyc = 1; cyc <= 120 + 4 * n; cyc++) begin
      if (vmode == 0) ofv = 1'b1;
      else if (vmode == 1) ofv = 1'($urandom_range(1, 0));
      else ofv = cyc >= 26 + n && ((cyc - 26 - n) % 2) == 0;
      @(negedge clk);
      if (!sram_cen) begin rd_a.push_back(int'(sram_a)); rd_c.push_back(cyc); end
      if (l0_wr) wr_c.push_back(cyc);
      if (l0_rd) l0rd_c.push_back(cyc);
      if (load) ld_c.push_back(cyc);
      if (execute) ex_c.push_back(cyc);
      if (!psum_cen) begin ps_a.push_back(int'(psum_a)); ps_c.push_back(cyc); end
      if (ofifo_rd) of_c.push_back(cyc);
      if (done) done_c.push_back(cyc);
      if (!busy) busy_gap++;
      if (sram_wen !== 1'b1 || (load && execute) || psum_cen !== psum_wen) viol++;
      e = ofv && cyc >= 26 && pops < n;
      if (e) begin pops++; exp_pop_last = cyc; end
      if (e != ofifo_rd) of_mis++;
      if (done) break;
      @(posedge clk); #1;
    end
    ofv = 1'b0;
    check({tag, " read count"}, rd_a.size(), 8 + n);
    m = 0;
    foreach (rd_a[i]) begin
      ea = i < 8 ? (w + i) & 2047 : (x + i - 8) & 2047;
      ec = i < 8 ? 1 + i : 18 + i;
      if (rd_a[i] != ea || rd_c[i] != ec) m++;
    end
    check({tag, " read addr/cycle mismatches"}, m, 0);
    m = wr_c.size() == rd_c.size() ? 0 : 1;
    foreach (wr_c[i]) if (i < rd_c.size() && wr_c[i] != rd_c[i] + 1) m++;
    check({tag, " l0_wr timing mismatches"}, m, 0);
    m = ld_c.size() == 16 ? 0 : 1;
    foreach (ld_c[i]) if (ld_c[i] != 10 + i) m++;
    check({tag, " load window mismatches"}, m, 0);
    m = l0rd_c.size() == 8 + n ? 0 : 1;
    foreach (l0rd_c[i]) if (l0rd_c[i] != (i < 8 ? 10 + i : 20 + i)) m++;
    check({tag, " l0_rd mismatches"}, m, 0);
    m = ex_c.size() == n ? 0 : 1;
    foreach (ex_c[i]) if (ex_c[i] != 28 + i) m++;
    check({tag, " execute mismatches"}, m, 0);
    check({tag, " ofifo_rd count"}, of_c.size(), n);
    check({tag, " ofifo_rd pattern mismatches"}, of_mis, 0);
    m = ps_a.size() == n ? 0 : 1;
    foreach (ps_a[i]) if (ps_a[i] != ((p + i) & 2047) || i >= of_c.size() || ps_c[i] != of_c[i] + 1) m++;
    check({tag, " psum write mismatches"}, m, 0);
    exp_done = n == 0 ? 26 : (28 + n > exp_pop_last + 2 ? 28 + n : exp_pop_last + 2);
    check({tag, " done pulses"}, done_c.size(), 1);
    check({tag, " done cycle"}, done_c.size() > 0 ? done_c[0] : -1, exp_done);
    check({tag, " busy gaps"}, busy_gap, 0);
    check({tag, " invariant violations"}, viol, 0);
  endtask
  initial begin
    int m;
    vecs[0] = '{"basic", 'h010, 'h100, 'h200, 4, 0, 12, 4, 'h103, 'h203};
    vecs[1] = '{"nlen0", 'h123, 'h456, 'h300, 0, 1, 8, 0, 'h12A, 0};
    vecs[2] = '{"wrap", 'h7FC, 'h7FE, 'h7FF, 4, 0, 12, 4, 'h001, 'h002};
    vecs[3] = '{"drain_toggle", 'h000, 'h020, 'h040, 4, 2, 12, 4, 'h023, 'h043};
    vecs[4] = '{"nlen1", 'h7FF, 'h000, 'h000, 1, 1, 9, 1, 'h000, 'h000};
    #3;
    check("reset outputs", int'(outs()), int'(11'b00110000011));
    check("reset sram_a", int'(sram_a), 0);
    check("reset psum_a", int'(psum_a), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_pass(vecs[i].name, vecs[i].w, vecs[i].x, vecs[i].p, vecs[i].n, vecs[i].vmode, 1'b0);
      check({vecs[i].name, " table reads"}, rd_a.size(), vecs[i].exp_reads);
      check({vecs[i].name, " table last read addr"}, rd_a.size() > 0 ? rd_a[$] : -1, vecs[i].exp_last_rd);
      check({vecs[i].name, " table psum writes"}, ps_a.size(), vecs[i].exp_writes);
      if (vecs[i].exp_writes > 0)
        check({vecs[i].name, " table last psum addr"}, ps_a.size() > 0 ? ps_a[$] : -1, vecs[i].exp_last_psum);
    end
    for (int r = 0; r < 6; r++)
      run_pass($sformatf("rand%0d", r), int'($urandom_range(2047, 0)), int'($urandom_range(2047, 0)),
               int'($urandom_range(2047, 0)), int'($urandom_range(20, 0)), int'($urandom_range(1, 0)), 1'b0);
    @(posedge clk); #1;
    w_base = 11'h010; x_base = 11'h100; psum_base = 11'h200; n_len = 11'd16; start = 1'b1; ofv = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    check("pre-reset streaming", int'({sram_cen, execute}), 1);
    rst = 1'b1;
    #1;
    check("mid-pass reset outputs", int'(outs()), int'(11'b00110000011));
    check("mid-pass reset sram_a", int'(sram_a), 0);
    check("mid-pass reset psum_a", int'(psum_a), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || !sram_cen || ofifo_rd || !psum_cen || done) m++;
    end
    check("idle after reset release", m, 0);
    ofv = 1'b0;
    run_pass("hold1", 'h055, 'h066, 'h077, 3, 0, 1'b1);
    @(posedge clk); #1 start = 1'b0;
    m = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) m++;
    end
    check("hold1 no second pass", m, 0);
    run_pass("hold2", 'h011, 'h022, 'h033, 2, 0, 1'b1);
    n_len = 11'd1; ofv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold2 idle cycle busy", int'(busy), 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("hold2 restart busy", int'(busy), 1);
    m = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin m = 1; break; end
    end
    check("hold2 restart done", m, 1);
    ofv = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
